mux_rr_4to1: RTL

Four-channel, parameter-width collector with valid/ready handshakes. It is the converging counterpart of the 1-to-4 data-routing demux. Each cycle it selects one requesting input channel by round-robin and registers that channel's data into a single output stage. A `last`-delimited burst holds the grant until the burst completes. It sits upstream of a shared consumer. `o_sel` identifies the source channel, so a downstream 1-to-4 demux can route responses back to it.

---
 rtl/mux_pkg.sv | 17 +
 rtl/rr_pick4.sv | 24 ++
 rtl/mux_rr_4to1.sv | 110 +++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the 4-to-1 round-robin collector.
// The channel count is fixed at four, so channel indices are always 2 bits wide.
package mux_pkg;

  localparam int NUM_CH = 4;
  localparam int IDX_W  = 2;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return IDX_W'((32'(idx) + 1) % NUM_CH);
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker.
// Returns the first set request bit, scanning from ptr upward modulo four.
module rr_pick4
  import mux_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [IDX_W-1:0]  gnt_idx,
  output logic              any
);

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_idx = ptr;
    any     = |req;
    // Walk from the farthest offset back to ptr so the closest requester wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req[ptr + IDX_W'(k)]) begin
        gnt_idx = ptr + IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux_rr_4to1.sv
// Four-channel round-robin collector with a registered output stage.
// A burst without last holds the grant on its channel until the last beat.
module mux_rr_4to1
  import mux_pkg::*;
#(
  parameter int width = 8,
  parameter int snum  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] i0,
  input  logic [width-1:0] i1,
  input  logic [width-1:0] i2,
  input  logic [width-1:0] i3,
  input  logic [3:0]       i_valid,
  input  logic [3:0]       i_last,
  output logic [3:0]       i_ready,
  output logic [width-1:0] o,
  output logic [snum-1:0]  o_sel,
  output logic             o_last,
  output logic             o_valid,
  input  logic             o_ready
);

  state_t            state, state_nxt;
  logic [snum-1:0]   ptr, ptr_nxt;
  logic [snum-1:0]   lch, lch_nxt;
  logic [snum-1:0]   arb_idx, gnt;
  logic              arb_any, elig, load, xfer;
  logic [width-1:0]  din [NUM_CH];

  assign din[0] = i0;
  assign din[1] = i1;
  assign din[2] = i2;
  assign din[3] = i3;

  rr_pick4 u_pick (
    .req     (i_valid),
    .ptr     (ptr),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  assign load = ~o_valid | o_ready;

  always_comb begin
    gnt       = arb_idx;
    elig      = arb_any;
    state_nxt = state;
    ptr_nxt   = ptr;
    lch_nxt   = lch;
    i_ready   = '0;
    // A locked channel is offered ready even while it idles mid-burst.
    if (state == LOCK) begin
      gnt  = lch;
      elig = 1'b1;
    end
    if (rst_n && load && elig) begin
      i_ready[gnt] = 1'b1;
    end
    xfer = i_valid[gnt] & i_ready[gnt];
    if (xfer) begin
      case (state)
        ARB: begin
          ptr_nxt = next_idx(gnt);
          if (!i_last[gnt]) begin
            state_nxt = LOCK;
            lch_nxt   = gnt;
          end
        end
        LOCK: begin
          if (i_last[gnt]) begin
            state_nxt = ARB;
          end
        end
        default: state_nxt = ARB;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB;
      ptr   <= '0;
      lch   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      lch   <= lch_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o       <= '0;
      o_sel   <= '0;
      o_last  <= 1'b0;
      o_valid <= 1'b0;
    end else if (xfer) begin
      o       <= din[gnt];
      o_sel   <= gnt;
      o_last  <= i_last[gnt];
      o_valid <= 1'b1;
    end else if (o_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
